// File: rtl/spi_flash_emulator.sv
// SPI mode-0 serial flash emulator (READ, FAST_READ, JEDEC ID, status) backed by an on-chip byte array.
// SPI pins are oversampled on i_clk: 2-flop sync + 1 edge-detect cycle, so o_miso moves 3 clk after a physical sck fall.
module spi_flash_emulator #(
  parameter int          MEM_BYTES  = 4096,
  parameter int          ADDR_BYTES = 3,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ss,
  input  logic                         i_sck,
  input  logic                         i_mosi,
  output logic                         o_miso,
  output logic                         o_active,
  input  logic                         i_load_en,
  input  logic [$clog2(MEM_BYTES)-1:0] i_load_addr,
  input  logic [7:0]                   i_load_data
);

  localparam int         AW      = $clog2(MEM_BYTES);
  localparam logic [1:0] LAST_AB = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STATUS, S_IGNORE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ss_s;
  logic [1:0]    r_sck_s;
  logic [1:0]    r_mosi_s;
  logic          r_sck_d;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_rx;
  logic [7:0]    r_tx;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_byte_cnt;
  logic          r_dummy;
  logic          r_fetch;
  logic          r_miso;
  logic          r_active;
  logic [7:0]    r_mem [MEM_BYTES];

  logic          w_ss;
  logic          w_sck_rise;
  logic          w_sck_fall;
  logic          w_byte_done;
  logic          w_sending;
  logic [7:0]    w_rx_byte;

  assign w_ss        = r_ss_s[1];
  assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s[1] & r_sck_d;
  assign w_rx_byte   = {r_rx, r_mosi_s[1]};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_sending   = (r_state == S_DATA) || (r_state == S_ID) || (r_state == S_STATUS);

  assign o_miso   = r_miso;
  assign o_active = r_active;

  // Sync flops reset to the idle bus levels so leaving reset does not look like a select.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ss_s   <= 2'b11;
      r_sck_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sck_d  <= 1'b0;
    end else begin
      r_ss_s   <= {r_ss_s[0], i_ss};
      r_sck_s  <= {r_sck_s[0], i_sck};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_sck_d  <= r_sck_s[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load_en && !r_active) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx       <= 7'd0;
      r_tx       <= 8'd0;
      r_addr     <= '0;
      r_byte_cnt <= 2'd0;
      r_dummy    <= 1'b0;
      r_fetch    <= 1'b0;
      r_miso     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_active <= ~w_ss;
      r_fetch  <= 1'b0;
      // Fetch lands one clk after the last bit's rise, well before the next fall drives bit 7.
      if (r_fetch) begin
        r_tx   <= r_mem[r_addr];
        r_addr <= r_addr + AW'(1);
      end
      if (w_ss) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
        r_dummy    <= 1'b0;
        r_miso     <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_state <= S_CMD;
      end else begin
        if (w_sck_rise) begin
          r_rx      <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_sck_fall) begin
          r_miso <= w_sending ? r_tx[3'd7 - r_bit_cnt] : 1'b0;
        end
        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              r_byte_cnt <= 2'd0;
              case (w_rx_byte)
                8'h03: begin r_state <= S_ADDR; r_dummy <= 1'b0; end
                8'h0B: begin r_state <= S_ADDR; r_dummy <= 1'b1; end
                8'h9F: begin r_state <= S_ID; r_tx <= JEDEC_ID[23:16]; r_byte_cnt <= 2'd1; end
                8'h05: begin r_state <= S_STATUS; r_tx <= 8'h00; end
                default: begin r_state <= S_IGNORE; r_tx <= 8'h00; end
              endcase
            end
            S_ADDR: begin
              r_addr <= AW'({r_addr, w_rx_byte});
              if (r_byte_cnt == LAST_AB) begin
                r_byte_cnt <= 2'd0;
                if (r_dummy) begin
                  r_state <= S_DUMMY;
                end else begin
                  r_state <= S_DATA;
                  r_fetch <= 1'b1;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end
            S_DUMMY: begin
              r_state <= S_DATA;
              r_fetch <= 1'b1;
            end
            S_DATA: r_fetch <= 1'b1;
            S_ID: begin
              case (r_byte_cnt)
                2'd1:    r_tx <= JEDEC_ID[15:8];
                2'd2:    r_tx <= JEDEC_ID[7:0];
                default: r_tx <= 8'h00;
              endcase
              if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_emulator.sv
// Directed bench for spi_flash_emulator: an SPI mode-0 master bit-bangs commands at clk/10 and checks returned bytes.
module tb_spi_flash_emulator;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        active;
  logic        load_en = 1'b0;
  logic [11:0] load_addr = 12'd0;
  logic [7:0]  load_data = 8'd0;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rd [8];
  logic [7:0]  junk;

  always #5 clk = ~clk;

  spi_flash_emulator #(
    .MEM_BYTES (4096),
    .ADDR_BYTES(3),
    .JEDEC_ID  (24'hEF4016)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ss       (ss),
    .i_sck      (sck),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_active   (active),
    .i_load_en  (load_en),
    .i_load_addr(load_addr),
    .i_load_data(load_data)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Mode 0: mosi set and miso sampled while sck is low, just before the rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic sel();
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic desel();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic body(input logic [7:0] cmd, input logic [23:0] addr, input int naddr,
                      input int ndummy, input int nrd);
    xfer(cmd, 8, junk);
    for (int b = naddr - 1; b >= 0; b--) xfer(addr[8*b +: 8], 8, junk);
    for (int d = 0; d < ndummy; d++) xfer(8'h00, 8, junk);
    for (int r = 0; r < nrd; r++) xfer(8'h00, 8, rd[r]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_miso", {7'd0, miso}, 8'h00);
    check("reset_active", {7'd0, active}, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    load(12'h010, 8'h11); load(12'h011, 8'h22); load(12'h012, 8'h33); load(12'h013, 8'h44);
    load(12'hFFF, 8'hA5); load(12'h000, 8'h5A);

    // Active latency around the select edge, then a 4-byte READ.
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    check("active_2clk", {7'd0, active}, 8'h00);
    @(negedge clk);
    check("active_3clk", {7'd0, active}, 8'h01);
    body(8'h03, 24'h000010, 3, 0, 4);
    desel();
    check("read_b0", rd[0], 8'h11);
    check("read_b1", rd[1], 8'h22);
    check("read_b2", rd[2], 8'h33);
    check("read_b3", rd[3], 8'h44);
    check("idle_active", {7'd0, active}, 8'h00);

    sel(); body(8'h0B, 24'h000FFF, 3, 1, 2); desel();
    check("fast_wrap_b0", rd[0], 8'hA5);
    check("fast_wrap_b1", rd[1], 8'h5A);

    sel(); body(8'h03, 24'hFF1010, 3, 0, 1); desel();
    check("addr_trunc", rd[0], 8'h11);

    sel(); body(8'h9F, 24'h0, 0, 0, 4); desel();
    check("jedec_b0", rd[0], 8'hEF);
    check("jedec_b1", rd[1], 8'h40);
    check("jedec_b2", rd[2], 8'h16);
    check("jedec_b3", rd[3], 8'h00);

    sel(); body(8'h05, 24'h0, 0, 0, 2); desel();
    check("status_b0", rd[0], 8'h00);
    check("status_b1", rd[1], 8'h00);

    sel(); body(8'h42, 24'h0, 0, 0, 2); desel();
    check("ignore_b0", rd[0], 8'h00);
    check("ignore_b1", rd[1], 8'h00);

    // Abort mid-address, then a clean READ.
    sel(); xfer(8'h03, 8, junk); xfer(8'hFF, 3, junk); desel();
    check("abort_active", {7'd0, active}, 8'h00);
    sel(); body(8'h03, 24'h000011, 3, 0, 1); desel();
    check("after_abort", rd[0], 8'h22);

    // Backdoor write while selected must be dropped.
    sel(); body(8'h03, 24'h000012, 3, 0, 1);
    load(12'h012, 8'hFF);
    desel();
    check("drop_first", rd[0], 8'h33);
    sel(); body(8'h03, 24'h000012, 3, 0, 1); desel();
    check("drop_readback", rd[0], 8'h33);

    // Reset during data bit 5 of mem[0]=5A (bit 5 on the wire is 1).
    sel(); body(8'h03, 24'h000000, 3, 0, 0);
    xfer(8'h00, 4, junk);
    repeat (4) @(negedge clk);
    check("pre_rst_miso", {7'd0, miso}, 8'h01);
    rst = 1'b1;
    #1;
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_active", {7'd0, active}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ss = 1'b1;
    repeat (8) @(negedge clk);
    sel(); body(8'h03, 24'h000010, 3, 0, 1); desel();
    check("post_rst_read", rd[0], 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
